// File: rtl/inst_enc_if.sv
// Request/response bundle for the instruction encoder.
// master drives requests and consumes results; slave is the encoder.
interface inst_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opc5;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [11:0] in_csr;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [7:0]  err_cnt;

  modport master (
    output in_valid, in_opc5, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
           in_csr, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_opc5, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
           in_csr, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err, err_cnt
  );
endinterface

// File: rtl/inst_enc.sv
// RV32 instruction encoder: fields + byte-offset immediate -> 32-bit word, 1-cycle latency.
// Results sit in a 2-entry FIFO; in_ready is a registered not-full, so no out_ready->in_ready path.
module inst_enc (
  input  logic       clk,
  input  logic       rst_n,
  inst_enc_if.slave  bus
);
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_ARI_I  = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_ARI_R  = 5'b01100;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  logic [31:0] w_imm;
  logic [4:0]  w_opc;
  logic [2:0]  w_f3;
  logic [31:0] w_inst;
  logic        w_err;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_cnt_nxt;

  logic [32:0] r_d0;
  logic [32:0] r_d1;
  logic [1:0]  r_cnt;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [7:0]  r_err_cnt;

  assign w_imm = bus.in_imm;
  assign w_opc = bus.in_opc5;
  assign w_f3  = bus.in_funct3;

  // Fields are always placed even when flagged, so a bad immediate is visibly truncated.
  always_comb begin
    w_inst = 32'h0000_0013;
    w_err  = 1'b1;
    case (w_opc)
      OPC_LUI, OPC_AUIPC: begin
        w_inst = {w_imm[31:12], bus.in_rd, w_opc, 2'b11};
        w_err  = |w_imm[11:0];
      end
      OPC_JAL: begin
        w_inst = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, w_opc, 2'b11};
        w_err  = w_imm[0] | (w_imm[31:21] != {11{w_imm[20]}});
      end
      OPC_JALR, OPC_LOAD, OPC_ARI_I: begin
        if (w_opc == OPC_ARI_I && w_f3[1:0] == 2'b01) begin
          w_inst = {bus.in_funct7, w_imm[4:0], bus.in_rs1, w_f3, bus.in_rd, w_opc, 2'b11};
          w_err  = |w_imm[31:5];
        end else begin
          w_inst = {w_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, w_opc, 2'b11};
          w_err  = (w_imm[31:12] != {20{w_imm[11]}});
        end
      end
      OPC_STORE: begin
        w_inst = {w_imm[11:5], bus.in_rs2, bus.in_rs1, w_f3, w_imm[4:0], w_opc, 2'b11};
        w_err  = (w_imm[31:12] != {20{w_imm[11]}});
      end
      OPC_BRANCH: begin
        w_inst = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, w_f3,
                  w_imm[4:1], w_imm[11], w_opc, 2'b11};
        w_err  = w_imm[0] | (w_imm[31:13] != {19{w_imm[12]}});
      end
      OPC_ARI_R: begin
        w_inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1, w_f3, bus.in_rd, w_opc, 2'b11};
        w_err  = 1'b0;
      end
      OPC_SYSTEM: begin
        w_inst = {bus.in_csr, (w_f3[2] ? w_imm[4:0] : bus.in_rs1), w_f3, bus.in_rd, w_opc, 2'b11};
        w_err  = w_f3[2] & (|w_imm[31:5]);
      end
      default: begin
        w_inst = 32'h0000_0013;
        w_err  = 1'b1;
      end
    endcase
  end

  assign w_push = bus.in_valid & r_in_ready;
  assign w_pop  = r_out_valid & bus.out_ready;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + 2'd1;
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_cnt - 2'd1;
    end
  end

  // r_d0 is the head and drives the outputs directly; r_d1 only holds the second entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d0        <= '0;
      r_d1        <= '0;
      r_cnt       <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_cnt_nxt != 2'd2);
      r_out_valid <= (w_cnt_nxt != 2'd0);
      if (w_push && w_err && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_pop) begin
        if (w_push && r_cnt == 2'd1) begin
          r_d0 <= {w_err, w_inst};
        end else begin
          r_d0 <= r_d1;
        end
      end else if (w_push) begin
        if (r_cnt == 2'd0) begin
          r_d0 <= {w_err, w_inst};
        end else begin
          r_d1 <= {w_err, w_inst};
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_inst  = r_d0[31:0];
  assign bus.out_err   = r_d0[32];
  assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_inst_enc.sv
// Scoreboard bench for inst_enc: driver pushes expected words, monitor pops on each output handshake.
module tb_inst_enc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  inst_enc_if u_if();

  inst_enc u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] csr;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   acc_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  int   rdy_mode = 1;
  bit          hold_pend = 1'b0;
  logic [31:0] held_inst;
  logic        held_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // true when v, read as signed, lies in the n-bit two's complement range
  function automatic bit fits(input logic [31:0] v, input int n);
    longint s;
    longint lim;
    s   = longint'($signed(v));
    lim = longint'(1) << (n - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  function automatic rsp_t ref_enc(input req_t r);
    rsp_t o;
    logic [31:0] base, rdp, f3p, rs1p, rs2p;
    base = {25'd0, r.opc, 2'b11};
    rdp  = 32'(r.rd) << 7;
    f3p  = 32'(r.f3) << 12;
    rs1p = 32'(r.rs1) << 15;
    rs2p = 32'(r.rs2) << 20;
    case (r.opc)
      5'b01101, 5'b00101: begin
        o.inst = (r.imm & 32'hFFFFF000) | rdp | base;
        o.err  = (r.imm % 32'd4096) != 32'd0;
      end
      5'b11011: begin
        o.inst = (fld(r.imm, 20, 20) << 31) | (fld(r.imm, 10, 1) << 21) |
                 (fld(r.imm, 11, 11) << 20) | (fld(r.imm, 19, 12) << 12) | rdp | base;
        o.err  = r.imm[0] || !fits(r.imm, 21);
      end
      5'b11001, 5'b00000, 5'b00100: begin
        if (r.opc == 5'b00100 && (r.f3 == 3'd1 || r.f3 == 3'd5)) begin
          o.inst = (32'(r.f7) << 25) | (fld(r.imm, 4, 0) << 20) | rs1p | f3p | rdp | base;
          o.err  = r.imm >= 32'd32;
        end else begin
          o.inst = (fld(r.imm, 11, 0) << 20) | rs1p | f3p | rdp | base;
          o.err  = !fits(r.imm, 12);
        end
      end
      5'b01000: begin
        o.inst = (fld(r.imm, 11, 5) << 25) | rs2p | rs1p | f3p | (fld(r.imm, 4, 0) << 7) | base;
        o.err  = !fits(r.imm, 12);
      end
      5'b11000: begin
        o.inst = (fld(r.imm, 12, 12) << 31) | (fld(r.imm, 10, 5) << 25) | rs2p | rs1p | f3p |
                 (fld(r.imm, 4, 1) << 8) | (fld(r.imm, 11, 11) << 7) | base;
        o.err  = r.imm[0] || !fits(r.imm, 13);
      end
      5'b01100: begin
        o.inst = (32'(r.f7) << 25) | rs2p | rs1p | f3p | rdp | base;
        o.err  = 1'b0;
      end
      5'b11100: begin
        o.inst = (32'(r.csr) << 20) | ((r.f3[2] ? fld(r.imm, 4, 0) : 32'(r.rs1)) << 15) |
                 f3p | rdp | base;
        o.err  = r.f3[2] && (r.imm >= 32'd32);
      end
      default: begin
        o.inst = 32'h0000_0013;
        o.err  = 1'b1;
      end
    endcase
    return o;
  endfunction

  function automatic req_t mk(input logic [4:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    req_t r;
    r.opc = opc; r.f3 = f3; r.f7 = 7'd0; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.csr = 12'd0; r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    logic [4:0] ops[10] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000,
                            5'b00100, 5'b01000, 5'b11000, 5'b01100, 5'b11100};
    r.opc = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 9)];
    r.f3  = 3'($urandom);
    r.f7  = 7'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.csr = 12'($urandom);
    case ($urandom_range(0, 4))
      0: r.imm = $urandom;
      1: r.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      2: r.imm = 32'($urandom_range(0, 40));
      3: r.imm = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 1));
      default: r.imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & ~32'd1;
    endcase
    return r;
  endfunction

  task automatic set_req(input req_t r);
    u_if.in_opc5   = r.opc;
    u_if.in_funct3 = r.f3;
    u_if.in_funct7 = r.f7;
    u_if.in_rd     = r.rd;
    u_if.in_rs1    = r.rs1;
    u_if.in_rs2    = r.rs2;
    u_if.in_csr    = r.csr;
    u_if.in_imm    = r.imm;
  endtask

  // Present r until accepted; the expectation is queued just before the accepting edge.
  task automatic drive(input req_t r, input rsp_t e);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      set_req(r);
      u_if.in_valid = 1'b1;
      #3;
      if (u_if.in_ready && rst_n) begin
        exp_q.push_back(e);
        if (e.err && model_cnt < 255) model_cnt++;
        acc_cyc.push_back(cyc);
        done = 1'b1;
      end else if (++n > 64) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout: in_ready stuck at %b", u_if.in_ready);
        done = 1'b1;
      end
    end
  endtask

  task automatic drive_rand();
    req_t r;
    r = rand_req();
    drive(r, ref_enc(r));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
  endtask

  // Called right after drive(): checks the word is visible one edge later.
  task automatic lat_check(input string name, input logic [31:0] inst, input logic err);
    @(posedge clk);
    #2;
    chk({name, "_vld"}, u_if.out_valid, 1);
    chk({name, "_inst"}, u_if.out_inst, inst);
    chk({name, "_err"}, u_if.out_err, err);
    u_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    u_if.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: u_if.out_ready = 1'b0;
        1: u_if.out_ready = 1'b1;
        default: u_if.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(posedge clk) begin
    rsp_t e;
    #2;
    chk("err_cnt", u_if.err_cnt, model_cnt);
    if (hold_pend) begin
      chk("hold_vld", u_if.out_valid, 1);
      chk("hold_inst", u_if.out_inst, held_inst);
      chk("hold_err", u_if.out_err, held_err);
    end
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
      hold_pend = 1'b0;
    end else begin
      if (u_if.out_valid && u_if.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h with nothing expected", u_if.out_inst);
        end else begin
          e = exp_q.pop_front();
          chk("out_inst", u_if.out_inst, e.inst);
          chk("out_err", u_if.out_err, e.err);
        end
      end
      hold_pend = u_if.out_valid && !u_if.out_ready;
      held_inst = u_if.out_inst;
      held_err  = u_if.out_err;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int offs[6] = '{0, 1, 4, 5, 6, 7};
    req_t r;
    u_if.in_valid = 1'b0;
    set_req(mk(5'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0));

    @(posedge clk);
    #2;
    chk("rst_vld", u_if.out_valid, 0);
    chk("rst_rdy", u_if.in_ready, 1);
    chk("rst_inst", u_if.out_inst, 0);
    chk("rst_err", u_if.out_err, 0);
    chk("rst_cnt", u_if.err_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();

    drive(mk(5'b01101, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000), '{32'h123452B7, 1'b0});
    lat_check("lui", 32'h123452B7, 1'b0);
    drive(mk(5'b11000, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC), '{32'hFE208EE3, 1'b0});
    lat_check("beq_m4", 32'hFE208EE3, 1'b0);
    drive(mk(5'b11000, 3'd0, 5'd0, 5'd1, 5'd2, 32'h00000003), '{32'h00208163, 1'b1});
    lat_check("beq_3", 32'h00208163, 1'b1);
    chk("beq_3_cnt", u_if.err_cnt, 1);
    drive(mk(5'b11011, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000800), '{32'h001000EF, 1'b0});
    lat_check("jal_800", 32'h001000EF, 1'b0);
    drive(mk(5'b11011, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00100000), '{32'h800000EF, 1'b1});
    lat_check("jal_big", 32'h800000EF, 1'b1);
    idle();

    rdy_mode = 2;
    repeat (400) begin
      drive_rand();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) idle();
    end
    idle();
    rdy_mode = 1;
    drain();

    // out_ready low for exactly three edges under continuous in_valid
    rdy_mode = 0;
    idle();
    idle();
    acc_cyc.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) drive_rand();
      end
      begin
        @(posedge clk);
        repeat (3) @(posedge clk);
        rdy_mode = 1;
      end
    join
    idle();
    drain();
    chk("bp_accepts", acc_cyc.size(), 6);
    if (acc_cyc.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("bp_off%0d", i), acc_cyc[i] - acc_cyc[0], offs[i]);
    end

    for (int i = 0; i < 300; i++) begin
      r = rand_req();
      r.opc = 5'b11111;
      drive(r, '{32'h00000013, 1'b1});
    end
    idle();
    drain();
    chk("sat_cnt", u_if.err_cnt, 255);

    // fill the FIFO, then reset with a request pending
    rdy_mode = 0;
    idle();
    drive_rand();
    drive_rand();
    @(posedge clk);
    #1;
    r = rand_req();
    r.opc = 5'b11111;
    set_req(r);
    u_if.in_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("mid_rst_vld", u_if.out_valid, 0);
    chk("mid_rst_rdy", u_if.in_ready, 1);
    chk("mid_rst_cnt", u_if.err_cnt, 0);
    chk("mid_rst_inst", u_if.out_inst, 0);
    #1;
    rst_n = 1'b1;
    u_if.in_valid = 1'b0;
    rdy_mode = 1;
    @(posedge clk);
    #2;
    chk("post_rst_vld", u_if.out_valid, 0);

    drive(mk(5'b01101, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000), '{32'h123452B7, 1'b0});
    lat_check("lui_post", 32'h123452B7, 1'b0);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
